mbinit_repairclk_sequencer: RTL and testbench
=============================================

MBINIT_REPAIRCLK_SEQUENCER -- requirements
Module: mbinit_repairclk_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 8: cycles waited after generator done before the detector result is sampled.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum cycles in PATTERN before the attempt is abandoned.
REQ-003 SHALL have parameter MAX_RETRY, default 2: maximum extra attempts when REPAIRCLK_RETRY_EN is defined.
REQ-004 SHALL have port i_clk, input, 1: the only clock.
REQ-005 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port i_start, input, 1: level request to run the clock-repair test, sampled in IDLE.
REQ-007 SHALL have port i_abort, input, 1: cancels any run.
REQ-008 SHALL have port i_gen_done, input, 1: repair-pattern-complete from the clock mode generator.
REQ-009 SHALL have port i_result_logged, input, 3: detector result {Track,CKN,CKP}.
REQ-010 SHALL have port i_sb_ack, input, 1: sideband accepted the result message.
REQ-011 SHALL have port o_valid, output, 1: to generator i_valid.
REQ-012 SHALL have port o_mode, output, 1: to generator i_mode.
REQ-013 SHALL have port o_state_indicator, output, 1: to generator i_state_indicator.
REQ-014 SHALL have port o_clear_out, output, 1: to detector clear_out.
REQ-015 SHALL have port o_sb_req, output, 1: result message valid.
REQ-016 SHALL have port o_sb_data, output, 3: result message payload.
REQ-017 SHALL have ports o_busy, o_done, o_pass and o_timeout, each output, 1: run status flags.
REQ-018 SHALL have port o_result, output, 3: the last captured result.
REQ-019 SHALL have port o_retry_cnt, output, 2: the number of retries used.

Function
REQ-020 SHALL implement states IDLE, CLEAR, PATTERN, SETTLE, CAPTURE, REPORT, DONE; o_busy=1 in every state except IDLE.
REQ-021 SHALL move IDLE->CLEAR on the cycle after i_start=1 is sampled; i_start outside IDLE is ignored.
REQ-022 SHALL assert o_clear_out for exactly one cycle in CLEAR, clear o_result/o_pass/o_timeout, then enter PATTERN.
REQ-023 SHALL in PATTERN drive o_state_indicator=1, o_valid=1, o_mode=0; exit to SETTLE when i_gen_done=1 is sampled.
REQ-024 SHALL count cycles in PATTERN; when count reaches TIMEOUT_CYCLES-1 with no i_gen_done, enter DONE with o_timeout=1, o_pass=0; i_gen_done on that same cycle wins (go to SETTLE).
REQ-025 SHALL in SETTLE drive generator controls to 0 and wait exactly SETTLE_CYCLES cycles, then enter CAPTURE.
REQ-026 SHALL in CAPTURE latch o_result=i_result_logged and o_pass=(i_result_logged==3'b111) for one cycle, then enter REPORT.
REQ-027 SHALL in REPORT hold o_sb_req=1 with o_sb_data=o_result stable until i_sb_ack=1 is sampled, then enter DONE; i_sb_ack outside REPORT is ignored.
REQ-028 SHALL pulse o_done for exactly one cycle in DONE, then return to IDLE; o_result/o_pass/o_timeout/o_retry_cnt hold until the next CLEAR.
REQ-029 SHALL on i_abort=1 in any non-IDLE state go to IDLE next cycle with all control outputs 0, o_pass=0, no o_done; i_abort beats any simultaneous event.
REQ-030 SHALL register all outputs (no combinational input-to-output path).

Reset
REQ-031 SHALL on i_rst=1 at a clock edge enter IDLE and drive every output and counter to 0, aborting any run mid-operation.
REQ-032 SHALL give i_rst priority over i_abort and i_start.

Configuration
REQ-033 SHALL, when REPAIRCLK_RETRY_EN is defined, go CAPTURE->CLEAR instead of REPORT on a failed result while o_retry_cnt<MAX_RETRY, incrementing o_retry_cnt (saturating); timeout is never retried.
REQ-034 SHALL, when REPAIRCLK_RETRY_EN is undefined, make a single attempt and tie o_retry_cnt to 0.

Verification
REQ-035 SHALL cover: SETTLE_CYCLES=4, i_start, i_gen_done at PATTERN cycle 10, result 3'b111, ack 2 cycles after req -> o_pass=1, o_sb_data=7, single o_done pulse.
REQ-036 SHALL cover: TIMEOUT_CYCLES=64, no i_gen_done -> o_timeout=1 after 64 PATTERN cycles, o_pass=0, o_sb_req never asserted.
REQ-037 SHALL cover: result 3'b101 with REPAIRCLK_RETRY_EN, MAX_RETRY=2, always failing -> three o_clear_out pulses, o_retry_cnt=2, o_pass=0, o_result=5.
REQ-038 SHALL cover: i_abort together with i_gen_done in PATTERN -> IDLE next cycle, o_done never pulses, o_busy=0.
REQ-039 SHALL cover: i_rst asserted while in REPORT -> all outputs 0 next cycle; a fresh i_start then completes normally.

Source files
------------

// File: rtl/mbinit_repairclk_sequencer.sv
// MBINIT repair-clock test sequencer: clears the detector, runs the generator pattern,
// settles, captures {Track,CKN,CKP} and reports it over sideband. Optional macro: REPAIRCLK_RETRY_EN.
module mbinit_repairclk_sequencer #(
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRY      = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_gen_done,
  input  logic [2:0] i_result_logged,
  input  logic       i_sb_ack,
  output logic       o_valid,
  output logic       o_mode,
  output logic       o_state_indicator,
  output logic       o_clear_out,
  output logic       o_sb_req,
  output logic [2:0] o_sb_data,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic       o_timeout,
  output logic [2:0] o_result,
  output logic [1:0] o_retry_cnt
);

  typedef enum logic [2:0] {IDLE, CLEAR, PATTERN, SETTLE, CAPTURE, REPORT, DONE} state_t;

  localparam int CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] ST_LAST = CW'(SETTLE_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          retry_ok;

`ifdef REPAIRCLK_RETRY_EN
  assign retry_ok = (int'(o_retry_cnt) < MAX_RETRY) && (o_retry_cnt != 2'b11);
`else
  assign retry_ok = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state             <= IDLE;
      cnt               <= '0;
      o_valid           <= 1'b0;
      o_mode            <= 1'b0;
      o_state_indicator <= 1'b0;
      o_clear_out       <= 1'b0;
      o_sb_req          <= 1'b0;
      o_sb_data         <= 3'd0;
      o_busy            <= 1'b0;
      o_done            <= 1'b0;
      o_pass            <= 1'b0;
      o_timeout         <= 1'b0;
      o_result          <= 3'd0;
      o_retry_cnt       <= 2'd0;
    end else if (i_abort && state != IDLE) begin
      // Abort wins over any event sampled on the same edge; captured result is kept.
      state             <= IDLE;
      cnt               <= '0;
      o_valid           <= 1'b0;
      o_state_indicator <= 1'b0;
      o_clear_out       <= 1'b0;
      o_sb_req          <= 1'b0;
      o_busy            <= 1'b0;
      o_done            <= 1'b0;
      o_pass            <= 1'b0;
    end else begin
      o_clear_out <= 1'b0;
      o_done      <= 1'b0;
      o_mode      <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          state       <= CLEAR;
          o_busy      <= 1'b1;
          o_clear_out <= 1'b1;
          o_result    <= 3'd0;
          o_pass      <= 1'b0;
          o_timeout   <= 1'b0;
          o_retry_cnt <= 2'd0;
        end
        CLEAR: begin
          state             <= PATTERN;
          o_valid           <= 1'b1;
          o_state_indicator <= 1'b1;
          cnt               <= '0;
        end
        PATTERN: if (i_gen_done) begin
          state             <= SETTLE;
          o_valid           <= 1'b0;
          o_state_indicator <= 1'b0;
          cnt               <= '0;
        end else if (cnt == TO_LAST) begin
          state             <= DONE;
          o_valid           <= 1'b0;
          o_state_indicator <= 1'b0;
          o_timeout         <= 1'b1;
          o_pass            <= 1'b0;
          o_done            <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        SETTLE: if (cnt == ST_LAST) state <= CAPTURE;
                else                cnt   <= cnt + 1'b1;
        CAPTURE: if (i_result_logged != 3'b111 && retry_ok) begin
          state       <= CLEAR;
          o_clear_out <= 1'b1;
          o_result    <= 3'd0;
          o_pass      <= 1'b0;
`ifdef REPAIRCLK_RETRY_EN
          o_retry_cnt <= o_retry_cnt + 2'd1;
`endif
        end else begin
          state     <= REPORT;
          o_result  <= i_result_logged;
          o_pass    <= (i_result_logged == 3'b111);
          o_sb_req  <= 1'b1;
          o_sb_data <= i_result_logged;
        end
        REPORT: if (i_sb_ack) begin
          state    <= DONE;
          o_sb_req <= 1'b0;
          o_done   <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mbinit_repairclk_sequencer.sv
// Randomized self-checking bench for mbinit_repairclk_sequencer against a per-run outcome model.
module tb_mbinit_repairclk_sequencer;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 64;
  localparam int MAXR    = 2;
`ifdef REPAIRCLK_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic i_clk = 1'b0, i_rst = 1'b1, i_start = 1'b0, i_abort = 1'b0, i_gen_done = 1'b0, i_sb_ack = 1'b0;
  logic [2:0] i_result_logged = 3'd0;
  logic o_valid, o_mode, o_state_indicator, o_clear_out, o_sb_req, o_busy, o_done, o_pass, o_timeout;
  logic [2:0] o_sb_data, o_result;
  logic [1:0] o_retry_cnt;
  int checks = 0, errors = 0;

  always #5 i_clk = ~i_clk;

  mbinit_repairclk_sequencer #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT), .MAX_RETRY(MAXR)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort), .i_gen_done(i_gen_done),
    .i_result_logged(i_result_logged), .i_sb_ack(i_sb_ack), .o_valid(o_valid), .o_mode(o_mode),
    .o_state_indicator(o_state_indicator), .o_clear_out(o_clear_out), .o_sb_req(o_sb_req),
    .o_sb_data(o_sb_data), .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_timeout(o_timeout),
    .o_result(o_result), .o_retry_cnt(o_retry_cnt));

  wire [16:0] all_out = {o_valid, o_mode, o_state_indicator, o_clear_out, o_sb_req, o_sb_data,
                         o_busy, o_done, o_pass, o_timeout, o_result, o_retry_cnt};

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk); #1;
  endtask

  // One full run with generator done at PATTERN cycle gd_at (0-based); a value >= TIMEOUT never completes.
  task automatic run(input int gd_at, input logic [2:0] res, input int ack_dly);
    int clears = 0, valids = 0, gaps = 0, reqs = 0, mode_hi = 0, pat = 0, cyc = 0;
    bit sbd_bad = 0, fin = 0, to, exp_pass;
    int attempts;
    to       = (gd_at >= TIMEOUT);
    exp_pass = !to && (res == 3'b111);
    attempts = (RETRY && !exp_pass && !to) ? MAXR + 1 : 1;
    i_result_logged = res;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    while (!fin && cyc < 3000) begin
      cyc++;
      if (o_clear_out) begin clears++; pat = 0; end
      if (o_valid) begin valids++; pat++; end
      if (o_mode) mode_hi++;
      if (o_busy && !o_valid && !o_clear_out && !o_sb_req && !o_done) gaps++;
      if (o_sb_req) begin reqs++; if (o_sb_data != res) sbd_bad = 1; end
      i_gen_done = o_valid && (pat - 1 == gd_at);
      i_sb_ack   = o_sb_req ? (reqs == ack_dly + 1) : 1'($urandom_range(0, 1));
      i_start    = (o_busy && !o_done) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (o_done) begin
        fin = 1;
        chk("pass_at_done", int'(o_pass), int'(exp_pass));
        chk("timeout_at_done", int'(o_timeout), int'(to));
      end else tick();
    end
    if (!fin) chk("run_bound", 0, 1);
    i_gen_done = 1'b0;
    tick();
    i_sb_ack = 1'b0;
    chk("done_one_cycle", int'(o_done), 0);
    chk("idle_busy", int'(o_busy), 0);
    chk("clear_pulses", clears, attempts);
    chk("pattern_cycles", valids, attempts * (to ? TIMEOUT : gd_at + 1));
    chk("settle_capture_cycles", gaps, to ? 0 : attempts * (SETTLE + 1));
    chk("sb_req_cycles", reqs, to ? 0 : ack_dly + 1);
    chk("sb_data", int'(sbd_bad), 0);
    chk("mode_low", mode_hi, 0);
    chk("pass_hold", int'(o_pass), int'(exp_pass));
    chk("timeout_hold", int'(o_timeout), int'(to));
    chk("result_hold", int'(o_result), to ? 0 : int'(res));
    chk("retry_cnt", int'(o_retry_cnt), attempts - 1);
  endtask

  // Abort raised together with gen_done at PATTERN cycle k.
  task automatic abort_run(input int k);
    int pat = 0, cyc = 0, dones = 0;
    i_result_logged = 3'b111;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    while (cyc < 200 && !(o_valid && pat == k)) begin
      cyc++;
      if (o_valid) pat++;
      if (!(o_valid && pat == k)) tick();
    end
    if (cyc >= 200) chk("abort_bound", 0, 1);
    i_abort = 1'b1;
    i_gen_done = 1'b1;
    tick();
    i_abort = 1'b0;
    i_gen_done = 1'b0;
    chk("abort_busy", int'(o_busy), 0);
    chk("abort_valid", int'(o_valid), 0);
    chk("abort_pass", int'(o_pass), 0);
    for (int i = 0; i < 12; i++) begin
      if (o_done || o_busy) dones++;
      tick();
    end
    chk("abort_no_done", dones, 0);
  endtask

  // Reset while waiting for sideband ack, with start also high to check reset priority.
  task automatic reset_in_report;
    int cyc = 0;
    i_result_logged = 3'b011;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    while (!o_sb_req && cyc < 200) begin cyc++; i_gen_done = o_valid; tick(); end
    i_gen_done = 1'b0;
    if (cyc >= 200) chk("report_bound", 0, 1);
    i_rst = 1'b1;
    i_start = 1'b1;
    i_abort = 1'b1;
    tick();
    chk("rst_in_report_outputs", int'(all_out), 0);
    i_rst = 1'b0;
    i_start = 1'b0;
    i_abort = 1'b0;
    tick();
    chk("rst_start_ignored", int'(o_busy), 0);
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_outputs", int'(all_out), 0);
    i_rst = 1'b0;
    tick();
    chk("idle_no_start", int'(o_busy), 0);
    run(10, 3'b111, 2);
    run(200, 3'b111, 0);
    run(TIMEOUT - 1, 3'b111, 1);
    run(TIMEOUT, 3'b110, 1);
    run(10, 3'b101, 1);
    run(0, 3'b000, 0);
    abort_run(5);
    abort_run(0);
    reset_in_report();
    run(7, 3'b111, 3);
    for (int n = 0; n < 12; n++) begin
      int gd;
      logic [2:0] r;
      gd = $urandom_range(0, 70);
      r  = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'($urandom_range(0, 7));
      run(gd, r, $urandom_range(0, 4));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
